// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample width, channel encoding and the stereo pair
// layout used by both the receive and transmit paths.
package i2s_pkg;

    localparam int I2S_DW = 16;

    // Channel encoding follows the ws pin level: 0 = left, 1 = right.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_t;

    // One stereo sample pair.
    typedef struct packed {
        logic [I2S_DW-1:0] left;
        logic [I2S_DW-1:0] right;
    } i2s_pair_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// Brings sck, ws and sd into the clk domain through an N-stage synchronizer
// and turns the synchronized sck into a one-cycle rise pulse. ws_s and sd_s get
// one extra register so they line up with the registered sck_rise pulse.
import i2s_pkg::*;

module i2s_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic ws,
    input  logic sd,
    output logic ws_s,
    output logic sd_s,
    output logic sck_rise
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ws_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic                   r_sck_prev;
    logic                   r_sck_rise;
    logic                   r_ws_d;
    logic                   r_sd_d;

    // Synchronizer chains plus registered sck rise detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_sync <= {SYNC_STAGES{1'b0}};
            r_ws_sync  <= {SYNC_STAGES{1'b0}};
            r_sd_sync  <= {SYNC_STAGES{1'b0}};
            r_sck_prev <= 1'b0;
            r_sck_rise <= 1'b0;
            r_ws_d     <= 1'b0;
            r_sd_d     <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], ws};
            r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], sd};
            r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
            r_sck_rise <= r_sck_sync[SYNC_STAGES-1] & ~r_sck_prev;
            r_ws_d     <= r_ws_sync[SYNC_STAGES-1];
            r_sd_d     <= r_sd_sync[SYNC_STAGES-1];
        end
    end

    assign ws_s     = r_ws_d;
    assign sd_s     = r_sd_d;
    assign sck_rise = r_sck_rise;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: assembles MSB-first words on each sck rise, pairs a left word
// with the following right word and holds the pair on a valid/ready output.
// A ws change marks the LSB of the word in progress (standard one-bit delay).
import i2s_pkg::*;

module i2s_rx #(
    parameter int DW          = I2S_DW,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sck,
    input  logic          ws,
    input  logic          sd,
    output logic [DW-1:0] left_data,
    output logic [DW-1:0] right_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun,
    output logic          locked
);

    localparam int CW = $clog2(DW + 1);
    localparam int IW = $clog2(DW);

    logic          w_ws_s;
    logic          w_sd_s;
    logic          w_sck_rise;
    logic          w_ws_chg;
    logic [IW-1:0] w_idx;
    logic [DW-1:0] w_shift_next;
    logic          w_pair_done;

    logic [DW-1:0] r_shift;
    logic [CW-1:0] r_bit_cnt;
    logic          r_ws_prev;
    ch_t           r_cur_ch;
    logic [DW-1:0] r_left_hold;
    logic          r_left_seen;
    logic          r_locked;
    logic [DW-1:0] r_left_data;
    logic [DW-1:0] r_right_data;
    logic          r_out_valid;
    logic          r_overrun;

    i2s_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .ws       (ws),
        .sd       (sd),
        .ws_s     (w_ws_s),
        .sd_s     (w_sd_s),
        .sck_rise (w_sck_rise)
    );

    // Shift register with the current bit placed; bits past DW are dropped.
    always_comb begin
        w_ws_chg     = w_ws_s ^ r_ws_prev;
        w_idx        = IW'(DW - 1) - r_bit_cnt[IW-1:0];
        w_shift_next = r_shift;
        if (r_bit_cnt < CW'(DW)) begin
            w_shift_next[w_idx] = w_sd_s;
        end else begin
            w_shift_next = r_shift;
        end
        w_pair_done = w_sck_rise & w_ws_chg & r_locked & (r_cur_ch == CH_RIGHT) & r_left_seen;
    end

    // Word assembly, channel tracking and lock acquisition on each bit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= {DW{1'b0}};
            r_bit_cnt   <= {CW{1'b0}};
            r_ws_prev   <= 1'b0;
            r_cur_ch    <= CH_LEFT;
            r_left_hold <= {DW{1'b0}};
            r_left_seen <= 1'b0;
            r_locked    <= 1'b0;
        end else if (w_sck_rise) begin
            r_ws_prev <= w_ws_s;
            if (w_ws_chg) begin
                if (r_locked && (r_cur_ch == CH_LEFT)) begin
                    r_left_hold <= w_shift_next;
                    r_left_seen <= 1'b1;
                end
                r_shift   <= {DW{1'b0}};
                r_bit_cnt <= {CW{1'b0}};
                r_cur_ch  <= ch_t'(w_ws_s);
                r_locked  <= 1'b1;
            end else begin
                r_shift <= w_shift_next;
                if (r_bit_cnt < CW'(DW)) begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
        end
    end

    // Output pair register: load when free or draining, else flag a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_left_data  <= {DW{1'b0}};
            r_right_data <= {DW{1'b0}};
            r_out_valid  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_pair_done) begin
            if (!r_out_valid || out_ready) begin
                r_left_data  <= r_left_hold;
                r_right_data <= w_shift_next;
                r_out_valid  <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign left_data  = r_left_data;
    assign right_data = r_right_data;
    assign out_valid  = r_out_valid;
    assign overrun    = r_overrun;
    assign locked     = r_locked;

endmodule
